gpio_pad_bank: RTL and testbench



---
 rtl/gpio_pad_bank.sv | 197 +++++++++++++++++++
 tb/tb_gpio_pad_bank.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/gpio_pad_bank.sv
// GPIO pad bank: iomem-bus register slave driving N_GPIO pads, with input sync and edge interrupts.
// Optional input debounce filter is built when GPIO_DEBOUNCE_EN is defined.

module gpio_pad_pin #(
    parameter int SYNC_STAGES = 2
) (
    input  logic pll_clk,
    input  logic reset,
`ifdef GPIO_DEBOUNCE_EN
    input  logic tick,
`endif
    input  logic din,
    output logic filt,
    output logic prev
);
    logic [SYNC_STAGES-1:0] sync;

    always_ff @(posedge pll_clk or posedge reset) begin
        if (reset) sync <= '0;
        else       sync <= {sync[SYNC_STAGES-2:0], din};
    end

`ifdef GPIO_DEBOUNCE_EN
    // filt follows the synchronised level only once it differs on 3 consecutive ticks
    logic [1:0] hold;
    always_ff @(posedge pll_clk or posedge reset) begin
        if (reset) begin
            filt <= 1'b0;
            hold <= 2'd0;
        end else if (tick) begin
            if (sync[SYNC_STAGES-1] == filt) hold <= 2'd0;
            else if (hold == 2'd2) begin
                filt <= sync[SYNC_STAGES-1];
                hold <= 2'd0;
            end else hold <= hold + 2'd1;
        end
    end
`else
    assign filt = sync[SYNC_STAGES-1];
`endif

    always_ff @(posedge pll_clk or posedge reset) begin
        if (reset) prev <= 1'b0;
        else       prev <= filt;
    end
endmodule

module gpio_pad_bank #(
    parameter int N_GPIO       = 16,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_DIV = 1024
) (
    input  logic              pll_clk,
    input  logic              reset,
    input  logic              iomem_valid,
    output logic              iomem_ready,
    input  logic [3:0]        iomem_wstrb,
    input  logic [7:0]        iomem_addr,
    input  logic [31:0]       iomem_wdata,
    output logic [31:0]       iomem_rdata,
    input  logic [N_GPIO-1:0] gpio_in,
    output logic [N_GPIO-1:0] gpio_out,
    output logic [N_GPIO-1:0] gpio_outenb,
    output logic              irq
);
    typedef enum logic {IDLE, ACK} state_t;

    state_t            state;
    logic [7:2]        req_addr;
    logic [3:0]        req_wstrb;
    logic [31:0]       req_wdata;

    logic [N_GPIO-1:0] data_out, outenb, rise_en, fall_en, irq_status;
    logic [N_GPIO-1:0] filt, prev;
    logic [N_GPIO-1:0] rd_val, wmask, wd, set_bits, clr_bits;
    logic [31:0]       rd_word, bmask;
    logic              commit;
    logic [2:0]        sel;

`ifdef GPIO_DEBOUNCE_EN
    localparam int PW = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;
    logic [PW-1:0] pre;
    logic          tick;

    assign tick = (pre == PW'(DEBOUNCE_DIV - 1));
    always_ff @(posedge pll_clk or posedge reset) begin
        if (reset)     pre <= '0;
        else if (tick) pre <= '0;
        else           pre <= pre + 1'b1;
    end
`endif

    for (genvar i = 0; i < N_GPIO; i++) begin : g_pin
        gpio_pad_pin #(.SYNC_STAGES(SYNC_STAGES)) u_pin (
            .pll_clk (pll_clk),
            .reset   (reset),
`ifdef GPIO_DEBOUNCE_EN
            .tick    (tick),
`endif
            .din     (gpio_in[i]),
            .filt    (filt[i]),
            .prev    (prev[i])
        );
    end

    // Register-side view of the captured request; acted on at the edge that ends ACK
    assign bmask    = {{8{req_wstrb[3]}}, {8{req_wstrb[2]}}, {8{req_wstrb[1]}}, {8{req_wstrb[0]}}};
    assign wmask    = bmask[N_GPIO-1:0];
    assign wd       = req_wdata[N_GPIO-1:0] & wmask;
    assign sel      = req_addr[4:2];
    assign commit   = (state == ACK) && (req_wstrb != 4'd0) && (req_addr[7:5] == 3'd0);
    assign set_bits = (filt & ~prev & rise_en) | (~filt & prev & fall_en);
    assign clr_bits = (commit && sel == 3'd5) ? wd : '0;

    always_comb begin
        rd_val = '0;
        case (iomem_addr[4:2])
            3'd0:    rd_val = data_out;
            3'd1:    rd_val = outenb;
            3'd2:    rd_val = filt;
            3'd3:    rd_val = rise_en;
            3'd4:    rd_val = fall_en;
            3'd5:    rd_val = irq_status;
            default: rd_val = '0;
        endcase
        rd_word = '0;
        if (iomem_addr[7:5] == 3'd0) rd_word[N_GPIO-1:0] = rd_val;
    end

    always_ff @(posedge pll_clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
            req_addr    <= '0;
            req_wstrb   <= '0;
            req_wdata   <= '0;
        end else begin
            case (state)
                IDLE: if (iomem_valid && !iomem_ready) begin
                    state       <= ACK;
                    iomem_ready <= 1'b1;
                    iomem_rdata <= rd_word;
                    req_addr    <= iomem_addr[7:2];
                    req_wstrb   <= iomem_wstrb;
                    req_wdata   <= iomem_wdata;
                end
                ACK: begin
                    state       <= IDLE;
                    iomem_ready <= 1'b0;
                    iomem_rdata <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge pll_clk or posedge reset) begin
        if (reset) begin
            data_out <= '0;
            outenb   <= '1;
            rise_en  <= '0;
            fall_en  <= '0;
        end else if (commit) begin
            case (sel)
                3'd0: data_out <= (data_out & ~wmask) | wd;
                3'd1: outenb   <= (outenb & ~wmask) | wd;
                3'd3: rise_en  <= (rise_en & ~wmask) | wd;
                3'd4: fall_en  <= (fall_en & ~wmask) | wd;
                3'd6: data_out <= data_out | wd;
                3'd7: data_out <= data_out & ~wd;
                default: ;
            endcase
        end
    end

    // A new edge in the same cycle as its W1C leaves the bit set
    always_ff @(posedge pll_clk or posedge reset) begin
        if (reset) irq_status <= '0;
        else       irq_status <= (irq_status & ~clr_bits) | set_bits;
    end

    always_ff @(posedge pll_clk or posedge reset) begin
        if (reset) begin
            gpio_out    <= '0;
            gpio_outenb <= '1;
        end else begin
            gpio_out    <= data_out;
            gpio_outenb <= outenb;
        end
    end

    assign irq = |irq_status;

    logic unused_ok;
    assign unused_ok = ^{iomem_addr[1:0], req_wdata, bmask, (DEBOUNCE_DIV > 0)};
endmodule

// File: tb/tb_gpio_pad_bank.sv
// Directed bench for gpio_pad_bank: register table plus timing/interrupt/reset sequences.
// Debounce sequence runs instead of the exact-latency ones when GPIO_DEBOUNCE_EN is defined.

module tb_gpio_pad_bank;
    logic        pll_clk = 1'b0;
    logic        reset = 1'b1;
    logic        iomem_valid = 1'b0;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb = 4'd0;
    logic [7:0]  iomem_addr = 8'd0;
    logic [31:0] iomem_wdata = 32'd0;
    logic [31:0] iomem_rdata;
    logic [15:0] gpio_in = 16'd0;
    logic [15:0] gpio_out, gpio_outenb;
    logic        irq;

    int errors = 0;
    int checks = 0;

    gpio_pad_bank #(.N_GPIO(16), .SYNC_STAGES(2), .DEBOUNCE_DIV(4)) dut (
        .pll_clk(pll_clk), .reset(reset), .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
        .iomem_rdata(iomem_rdata), .gpio_in(gpio_in), .gpio_out(gpio_out),
        .gpio_outenb(gpio_outenb), .irq(irq)
    );

    always #5 pll_clk = ~pll_clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Called on a negedge; returns on the negedge where ready is seen high
    task automatic bus(input logic [7:0] a, input logic [3:0] s, input logic [31:0] d,
                       output logic [31:0] q);
        bit got = 1'b0;
        q = '0;
        iomem_addr = a; iomem_wstrb = s; iomem_wdata = d; iomem_valid = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge pll_clk);
            if (iomem_ready) begin
                got = 1'b1;
                q = iomem_rdata;
            end
        end
        iomem_valid = 1'b0; iomem_wstrb = 4'd0; iomem_wdata = 32'd0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL bus_timeout: addr %h got no ready expected ready", a);
        end
    endtask

    task automatic rd(input string name, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] q;
        bus(a, 4'd0, 32'd0, q);
        check(name, q, exp);
        @(negedge pll_clk);
    endtask

    task automatic wr(input logic [7:0] a, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] q;
        bus(a, s, d, q);
        @(negedge pll_clk);
    endtask

    typedef struct {
        logic [7:0]  addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[17];

    initial begin
        logic [31:0] q;
        // wstrb==0 rows are reads compared against exp
        tbl[0]  = '{8'h00, 4'b0001, 32'h0000A5A5, 32'h0};
        tbl[1]  = '{8'h00, 4'b0000, 32'h0,        32'h000000A5};
        tbl[2]  = '{8'h18, 4'b1111, 32'h00000100, 32'h0};
        tbl[3]  = '{8'h00, 4'b0000, 32'h0,        32'h000001A5};
        tbl[4]  = '{8'h1C, 4'b1111, 32'h00000005, 32'h0};
        tbl[5]  = '{8'h00, 4'b0000, 32'h0,        32'h000001A0};
        tbl[6]  = '{8'h04, 4'b0000, 32'h0,        32'h0000FFFF};
        tbl[7]  = '{8'h04, 4'b0101, 32'hFFFF0F0F, 32'h0};
        tbl[8]  = '{8'h04, 4'b0000, 32'h0,        32'h0000FF0F};
        tbl[9]  = '{8'h0C, 4'b1111, 32'hFFFF0009, 32'h0};
        tbl[10] = '{8'h0C, 4'b0000, 32'h0,        32'h00000009};
        tbl[11] = '{8'h20, 4'b0000, 32'h0,        32'h0};
        tbl[12] = '{8'h20, 4'b1111, 32'hFFFFFFFF, 32'h0};
        tbl[13] = '{8'h00, 4'b0000, 32'h0,        32'h000001A0};
        tbl[14] = '{8'h1C, 4'b0000, 32'h0,        32'h0};
        tbl[15] = '{8'h18, 4'b0000, 32'h0,        32'h0};
        tbl[16] = '{8'h10, 4'b0000, 32'h0,        32'h0};

        repeat (3) @(negedge pll_clk);
        check("reset_ready", {31'd0, iomem_ready}, 32'd0);
        check("reset_rdata", iomem_rdata, 32'd0);
        check("reset_gpio_out", {16'd0, gpio_out}, 32'd0);
        check("reset_outenb", {16'd0, gpio_outenb}, 32'h0000FFFF);
        check("reset_irq", {31'd0, irq}, 32'd0);
        reset = 1'b0;
        @(negedge pll_clk);

        for (int i = 0; i < 17; i++) begin
            bus(tbl[i].addr, tbl[i].wstrb, tbl[i].wdata, q);
            if (tbl[i].wstrb == 4'd0) check($sformatf("vec%0d_rdata", i), q, tbl[i].exp);
            @(negedge pll_clk);
        end
        check("pin_gpio_out", {16'd0, gpio_out}, 32'h000001A0);
        check("pin_outenb", {16'd0, gpio_outenb}, 32'h0000FF0F);

        // gpio_out lags the commit edge by one cycle; ready never back-to-back
        bus(8'h18, 4'b1111, 32'h00000002, q);
        @(negedge pll_clk);
        check("no_b2b_ready", {31'd0, iomem_ready}, 32'd0);
        check("out_lag_old", {16'd0, gpio_out}, 32'h000001A0);
        @(negedge pll_clk);
        check("out_lag_new", {16'd0, gpio_out}, 32'h000001A2);

`ifndef GPIO_DEBOUNCE_EN
        // rise on pin0: irq exactly SYNC_STAGES+1 edges after the pad change
        gpio_in[0] = 1'b1;
        @(negedge pll_clk); check("rise0_irq_e0", {31'd0, irq}, 32'd0);
        @(negedge pll_clk); check("rise0_irq_e1", {31'd0, irq}, 32'd0);
        @(negedge pll_clk); check("rise0_irq_e2", {31'd0, irq}, 32'd1);
        rd("rise0_data_in", 8'h08, 32'h00000001);
        rd("rise0_status", 8'h14, 32'h00000001);
        bus(8'h14, 4'b1111, 32'h00000001, q);
        check("w1c_irq_ack", {31'd0, irq}, 32'd1);
        @(negedge pll_clk);
        check("w1c_irq_after", {31'd0, irq}, 32'd0);
        gpio_in[0] = 1'b0;
        repeat (5) @(negedge pll_clk);
        check("fall0_no_irq", {31'd0, irq}, 32'd0);
        rd("fall0_status", 8'h14, 32'h0);
        rd("fall0_data_in", 8'h08, 32'h0);

        // pin3 pending, then new rise lands on the same edge as its W1C
        gpio_in[3] = 1'b1;
        repeat (4) @(negedge pll_clk);
        check("rise3_irq", {31'd0, irq}, 32'd1);
        gpio_in[3] = 1'b0;
        repeat (4) @(negedge pll_clk);
        gpio_in[3] = 1'b1;
        @(negedge pll_clk);
        bus(8'h14, 4'b1111, 32'h00000008, q);
        @(negedge pll_clk);
        check("w1c_vs_set_irq", {31'd0, irq}, 32'd1);
        rd("w1c_vs_set_status", 8'h14, 32'h00000008);
        wr(8'h0C, 4'b1111, 32'h0);
        rd("rise_en_off_status", 8'h14, 32'h00000008);
        wr(8'h14, 4'b0010, 32'h00000008);
        rd("w1c_wrong_byte", 8'h14, 32'h00000008);
        wr(8'h14, 4'b0001, 32'h00000008);
        check("w1c3_irq", {31'd0, irq}, 32'd0);

        // falling edge with FALL_EN; left pending for the reset check
        wr(8'h10, 4'b1111, 32'h00000008);
        gpio_in[3] = 1'b0;
        repeat (4) @(negedge pll_clk);
        rd("fall3_status", 8'h14, 32'h00000008);
        check("fall3_irq", {31'd0, irq}, 32'd1);
`else
        // tick every 4 cycles: a 4-cycle pulse spans one tick only
        wr(8'h0C, 4'b1111, 32'h00000004);
        gpio_in[2] = 1'b1;
        repeat (4) @(negedge pll_clk);
        gpio_in[2] = 1'b0;
        repeat (30) @(negedge pll_clk);
        check("glitch_irq", {31'd0, irq}, 32'd0);
        rd("glitch_data_in", 8'h08, 32'h0);
        gpio_in[2] = 1'b1;
        repeat (30) @(negedge pll_clk);
        check("held_irq", {31'd0, irq}, 32'd1);
        rd("held_data_in", 8'h08, 32'h00000004);
        rd("held_status", 8'h14, 32'h00000004);
`endif

        // reset while ready is high: everything drops at once, write lost
        iomem_addr = 8'h04; iomem_wstrb = 4'b1111; iomem_wdata = 32'h0; iomem_valid = 1'b1;
        @(negedge pll_clk);
        check("midtx_ready_pre", {31'd0, iomem_ready}, 32'd1);
        reset = 1'b1;
        #1;
        check("midtx_ready", {31'd0, iomem_ready}, 32'd0);
        check("midtx_outenb", {16'd0, gpio_outenb}, 32'h0000FFFF);
        check("midtx_gpio_out", {16'd0, gpio_out}, 32'd0);
        check("midtx_irq", {31'd0, irq}, 32'd0);
        iomem_valid = 1'b0; iomem_wstrb = 4'd0;
        gpio_in = 16'd0;
        @(negedge pll_clk);
        reset = 1'b0;
        @(negedge pll_clk);
        rd("post_reset_outenb", 8'h04, 32'h0000FFFF);
        rd("post_reset_data_out", 8'h00, 32'h0);
        rd("post_reset_status", 8'h14, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
